if_stage: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the fetch PC, issues requests to the instruction SRAM over a request/acknowledge interface, and holds the fetched instruction in a one-entry output register until ID accepts it. It consumes the branch decision (`br_taken`/`br_target`) that ID resolves, honouring the MIPS branch-delay slot. It also consumes the exception/ERET redirect (`flush`/`flush_pc`).

---
 rtl/if_stage_pkg.sv | 14 +
 rtl/if_stage_if.sv | 21 ++
 rtl/if_stage.sv | 132 +++++++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: boot and exception vectors plus the fetch-state encoding.
package if_stage_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC    = 32'hBFC0_0000;
    localparam word_t EXC_VEC_BEV = 32'hBFC0_0380;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction SRAM request/acknowledge bus between the fetch stage (master) and the SRAM (slave).
interface if_stage_if;
    import if_stage_pkg::*;

    logic  inst_req;
    word_t inst_addr;
    logic  inst_addr_ok;
    logic  inst_data_ok;
    word_t inst_rdata;

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata
    );

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata
    );

endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, keeps one SRAM request in flight and holds
// one fetched instruction for ID, applying delay-slot branch redirects and exception flushes.
module if_stage
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    if_stage_if.master sram,
    output logic       if_valid,
    output word_t      if_pc,
    output word_t      if_inst,
    input  logic       id_allowin,
    input  logic       br_taken,
    input  word_t      br_pc,
    input  word_t      br_target,
    input  logic       flush,
    input  word_t      flush_pc
);

    fetch_state_e r_state;
    word_t        r_fetch_pc;
    word_t        r_req_pc;
    word_t        r_br_pend_tgt;
    word_t        r_if_pc;
    word_t        r_if_inst;
    logic         r_if_valid;
    logic         r_br_pend;
    logic         r_cancel;

    word_t w_ds_pc;
    word_t w_after_ds_pc;
    logic  w_transfer;
    logic  w_accept;
    logic  w_wait_wrong;
    logic  w_ds_next;
    logic  w_ds_issued;
    logic  w_br_cancel;
    logic  w_br_drop;
    logic  w_fl_cancel;

    assign w_ds_pc       = br_pc + 32'd4;
    assign w_after_ds_pc = br_pc + 32'd8;

    // Gated by resetn so the SRAM sees no request while the core is held in reset.
    assign sram.inst_req  = resetn & (r_state == S_REQ) & ~r_cancel & (~r_if_valid | id_allowin);
    assign sram.inst_addr = r_fetch_pc;

    assign w_transfer   = r_if_valid & id_allowin;
    assign w_accept     = sram.inst_req & sram.inst_addr_ok;

    // The in-flight request is the wrong-path instruction right after the delay slot.
    assign w_wait_wrong = (r_state == S_WAIT) & (r_req_pc == w_after_ds_pc);
    assign w_ds_next    = (r_fetch_pc == w_ds_pc);
    assign w_ds_issued  = (r_fetch_pc == w_after_ds_pc) | w_wait_wrong;

    assign w_br_cancel  = (w_accept & (r_fetch_pc == w_after_ds_pc))
                        | (w_wait_wrong & ~sram.inst_data_ok);
    assign w_br_drop    = br_taken & w_wait_wrong & sram.inst_data_ok;
    assign w_fl_cancel  = ((r_state == S_WAIT) & ~sram.inst_data_ok) | w_accept;

    // NOTE: every assignment here is non-blocking, so a later statement in this block overrides an
    // earlier one in the same cycle; the ordering below encodes flush > branch > sequential advance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= S_REQ;
            r_fetch_pc    <= RESET_PC;
            r_req_pc      <= '0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_inst     <= '0;
            r_br_pend     <= 1'b0;
            r_br_pend_tgt <= '0;
            r_cancel      <= 1'b0;
        end else begin
            if (w_transfer) begin
                r_if_valid <= 1'b0;
            end

            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        r_req_pc   <= r_fetch_pc;
                        r_fetch_pc <= r_br_pend ? r_br_pend_tgt : r_fetch_pc + 32'd4;
                        r_br_pend  <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sram.inst_data_ok) begin
                        r_state <= S_REQ;
                        if (r_cancel) begin
                            r_cancel <= 1'b0;
                        end else if (!w_br_drop) begin
                            r_if_valid <= 1'b1;
                            r_if_pc    <= r_req_pc;
                            r_if_inst  <= sram.inst_rdata;
                        end
                    end
                end
            endcase

            if (flush) begin
                r_fetch_pc <= flush_pc;
                r_if_valid <= 1'b0;
                r_br_pend  <= 1'b0;
                if (w_fl_cancel) begin
                    r_cancel <= 1'b1;
                end
            end else if (br_taken) begin
                if (w_ds_next) begin
                    // Delay slot leaving this very cycle: its successor is the target itself.
                    if (w_accept) begin
                        r_fetch_pc <= br_target;
                    end else begin
                        r_br_pend     <= 1'b1;
                        r_br_pend_tgt <= br_target;
                    end
                end else if (w_ds_issued) begin
                    r_fetch_pc <= br_target;
                    if (w_br_cancel) begin
                        r_cancel <= 1'b1;
                    end
                end
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_pc    = r_if_pc;
    assign if_inst  = r_if_inst;

endmodule
